// File: rtl/round_palette_ctrl.sv
// Banked 12-bit colour palette: reset-time fill, frame-synchronous bank select/blink, 2-cycle read.
// Optional fade-in on the output stage is compiled in by defining PALETTE_FADE_EN.
module round_palette_ctrl #(
  parameter int INDEX_W      = 4,
  parameter int NUM_BANKS    = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         frame_start,
  input  logic                         pix_valid,
  input  logic [INDEX_W-1:0]           index,
  input  logic [$clog2(NUM_BANKS)-1:0] bank_sel,
  input  logic                         blink_en,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_BANKS)-1:0] wr_bank,
  input  logic [INDEX_W-1:0]           wr_addr,
  input  logic [11:0]                  wr_data,
  output logic                         init_busy,
  output logic [3:0]                   red,
  output logic [3:0]                   green,
  output logic [3:0]                   blue,
  output logic                         rgb_valid
);
  // state | meaning
  // INIT  | filling every entry, one per cycle, bank-major; writes/frames ignored
  // RUN   | normal display reads, host writes and bank switching
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ADDR_W = BANK_W + INDEX_W;
  localparam int DEPTH  = NUM_BANKS * (2 ** INDEX_W);
  localparam logic [ADDR_W-1:0] INIT_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_init_addr;
  logic [BANK_W-1:0] r_active_bank;
  logic [7:0]        r_blink_cnt;
  logic              r_phase;
  logic [11:0]       r_mem [0:DEPTH-1];
  logic [11:0]       r_rd_data;
  logic              r_vld1;
  logic              r_vld2;
  logic [11:0]       r_rgb;

  logic              w_run;
  logic              w_wr_ok;
  logic [BANK_W-1:0] w_bank_alt;
  logic [11:0]       w_init_data;
  logic [11:0]       w_stage2;

  assign w_run       = (r_state == ST_RUN);
  assign w_wr_ok     = !Reset && w_run && wr_en && (int'(wr_bank) < NUM_BANKS);
  assign w_bank_alt  = (int'(bank_sel) >= NUM_BANKS - 1) ? '0 : bank_sel + BANK_W'(1);
  assign w_init_data = (r_init_addr[INDEX_W-1:0] == '0) ? 12'h000 : 12'h8D0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= ST_INIT;
      r_init_addr   <= '0;
      r_active_bank <= '0;
      r_blink_cnt   <= '0;
      r_phase       <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_addr == INIT_LAST) begin
            r_init_addr <= '0;
            r_state     <= ST_RUN;
          end else begin
            r_init_addr <= r_init_addr + ADDR_W'(1);
          end
        end
        default: begin
          if (frame_start) begin
            if (!blink_en) begin
              r_active_bank <= bank_sel;
              r_blink_cnt   <= '0;
              r_phase       <= 1'b0;
            end else begin
              // the phase held during the frame that just ended selects the new bank
              r_active_bank <= r_phase ? w_bank_alt : bank_sel;
              if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
              end else begin
                r_blink_cnt <= r_blink_cnt + 8'd1;
              end
            end
          end
        end
      endcase
    end
  end

  // read-first storage: the registered read sees the value before a same-edge write
  always_ff @(posedge Clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_init_addr] <= w_init_data;
    end else if (w_wr_ok) begin
      r_mem[{wr_bank, wr_addr}] <= wr_data;
    end
    r_rd_data <= r_mem[{r_active_bank, index}];
  end

`ifdef PALETTE_FADE_EN
  logic [3:0] r_fade_level;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fade_level <= '0;
    end else if (w_run && frame_start && (r_fade_level != 4'hF)) begin
      r_fade_level <= r_fade_level + 4'd1;
    end
  end

  function automatic logic [3:0] fade_ch(input logic [3:0] c, input logic [3:0] lvl);
    return 4'(({4'b0000, c} * ({4'b0000, lvl} + 8'd1)) >> 4);
  endfunction

  assign w_stage2 = {fade_ch(r_rd_data[11:8], r_fade_level),
                     fade_ch(r_rd_data[7:4],  r_fade_level),
                     fade_ch(r_rd_data[3:0],  r_fade_level)};
`else
  assign w_stage2 = r_rd_data;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_vld1 <= 1'b0;
      r_vld2 <= 1'b0;
      r_rgb  <= '0;
    end else begin
      r_vld1 <= pix_valid && w_run;
      r_vld2 <= r_vld1;
      r_rgb  <= r_vld1 ? w_stage2 : 12'h000;
    end
  end

  assign init_busy          = (r_state == ST_INIT);
  assign {red, green, blue} = r_rgb;
  assign rgb_valid          = r_vld2;
endmodule

// File: tb/tb_round_palette_ctrl.sv
// Scoreboard bench for round_palette_ctrl: expected pixels queued at drive time, compared at output.
module tb_round_palette_ctrl;
  localparam int INDEX_W = 4;
  localparam int NB      = 3;
  localparam int BF      = 2;
  localparam int BW      = $clog2(NB);
  localparam int ENTRIES = 2 ** INDEX_W;

  logic               Clk = 1'b0;
  logic               Reset, frame_start, pix_valid, blink_en, wr_en;
  logic [INDEX_W-1:0] index, wr_addr;
  logic [BW-1:0]      bank_sel, wr_bank;
  logic [11:0]        wr_data;
  logic               init_busy, rgb_valid;
  logic [3:0]         red, green, blue;

  typedef struct {
    int          due;
    logic        vld;
    logic [11:0] rgb;
  } sb_t;

  sb_t         sb[$];
  logic [11:0] m_mem [NB][ENTRIES];
  int          m_bank;
  int          m_fade;
  int          cyc;
  int          n_checks;
  int          n_errors;
  int          ph_seq [5] = '{0, 0, 1, 1, 0};

  round_palette_ctrl #(.INDEX_W(INDEX_W), .NUM_BANKS(NB), .BLINK_FRAMES(BF)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .index(index), .bank_sel(bank_sel), .blink_en(blink_en), .wr_en(wr_en),
    .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data), .init_busy(init_busy),
    .red(red), .green(green), .blue(blue), .rgb_valid(rgb_valid)
  );

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    sb_t e;
    @(posedge Clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("rgb_valid", 32'(rgb_valid), 32'(e.vld));
      chk("rgb", 32'({red, green, blue}), 32'(e.rgb));
    end
  endtask

  function automatic logic [11:0] fade_exp(input logic [11:0] c);
`ifdef PALETTE_FADE_EN
    logic [11:0] r;
    for (int k = 0; k < 3; k++) r[k*4 +: 4] = 4'((int'(c[k*4 +: 4]) * (m_fade + 1)) >> 4);
    return r;
`else
    return c;
`endif
  endfunction

  task automatic init_model();
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < ENTRIES; i++) m_mem[b][i] = (i == 0) ? 12'h000 : 12'h8D0;
    m_bank = 0;
    m_fade = 0;
  endtask

  task automatic rd(input int idx, input logic vld);
    sb_t e;
    index     = INDEX_W'(idx);
    pix_valid = vld;
    e.due = cyc + 2;
    e.vld = vld;
    e.rgb = vld ? fade_exp(m_mem[m_bank][idx]) : 12'h000;
    sb.push_back(e);
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic wr(input int b, input int a, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_bank = BW'(b);
    wr_addr = INDEX_W'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (b < NB) m_mem[b][a] = d;
  endtask

  task automatic frame(input int sel, input logic blink);
    tick();
    tick();
    bank_sel    = BW'(sel);
    blink_en    = blink;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (m_fade < 15) m_fade++;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_valid", 32'(rgb_valid), 32'd0);
    chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    Reset = 1'b0;
    init_model();
  endtask

  // host activity during INIT (pixels, a write, a frame pulse) must leave no trace
  task automatic wait_init(input string tag);
    int cnt = 0;
    pix_valid = 1'b1;
    index     = 4'd7;
    wr_en     = 1'b1;
    wr_bank   = '0;
    wr_addr   = 4'd7;
    wr_data   = 12'hFFF;
    while (init_busy === 1'b1 && cnt < 500) begin
      chk("init_valid", 32'(rgb_valid), 32'd0);
      chk("init_rgb", 32'({red, green, blue}), 32'd0);
      frame_start = (cnt == 5);
      bank_sel    = 1;
      tick();
      cnt++;
    end
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    wr_en       = 1'b0;
    chk(tag, 32'(cnt), 32'(NB * ENTRIES));
  endtask

  initial begin
    {Reset, frame_start, pix_valid, blink_en, wr_en} = '0;
    index = '0; wr_addr = '0; bank_sel = '0; wr_bank = '0; wr_data = '0;
    cyc = 0; n_checks = 0; n_errors = 0;
    init_model();

    do_reset();
    wait_init("init_cycles");

    rd(0, 1'b1); rd(5, 1'b1); rd(7, 1'b1); rd(5, 1'b0); rd(9, 1'b1);

    wr(1, 3, 12'hF0A);
    bank_sel = 1;
    rd(3, 1'b1);
    frame(1, 1'b0); m_bank = 1;
    rd(3, 1'b1); rd(0, 1'b1);

    wr_en = 1'b1; wr_bank = 1; wr_addr = 5; wr_data = 12'h123;
    rd(5, 1'b1);
    wr_en = 1'b0; m_mem[1][5] = 12'h123;
    rd(5, 1'b1);

    wr(3, 6, 12'hABC);
    rd(6, 1'b1);

    wr(2, 4, 12'h5A5);
    for (int k = 0; k < 5; k++) begin
      frame(0, 1'b1); m_bank = ph_seq[k];
      rd(3, 1'b1); rd(4, 1'b1);
    end
    frame(2, 1'b0); m_bank = 2;
    rd(4, 1'b1);
    for (int k = 0; k < 5; k++) begin
      frame(2, 1'b1); m_bank = ph_seq[k] ? 0 : 2;
      rd(4, 1'b1); rd(3, 1'b1); rd(4, 1'b0);
    end
    tick(); tick();

    do_reset();
    wait_init("rerun_init_cycles");
    rd(3, 1'b1);
    tick(); tick();

    do_reset();
    repeat (10) tick();
    do_reset();
    wait_init("midinit_cycles");

    wr(0, 3, 12'h111);
    wr(1, 3, 12'h222);
    rd(3, 1'b1);
    frame(1, 1'b0); m_bank = 1;
    rd(3, 1'b1); rd(5, 1'b1);
    frame(0, 1'b0); m_bank = 0;
    rd(7, 1'b1); rd(0, 1'b1);
    tick(); tick(); tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
